mux_dff_sched: RTL
==================

Name: mux_dff_sched

Overview:
- Shares a single 2:1-mux D flip-flop (inputs d0, d1, sel, rst; output q) between NREQ requesters.
- Round-robin arbitration; each granted operation drives one write through the chosen mux leg.
- Reads q back one cycle after capture and returns q plus a mismatch flag to the requester.
- Also sequences reset-checks of the flop. Sits between the test/control agents and the mux-DFF datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CNT_W, 8, width of saturating error counter.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-low reset (rst==0 resets on posedge clk).
- req  input  NREQ  per-requester operation request, level, held until ack.
- req_bit  input  NREQ  data bit to load, per requester.
- req_path  input  NREQ  0 = load through d0 leg, 1 = load through d1 leg.
- clr_req  input  1  request a flop reset-check; priority over req.
- dff_d0  output  1  to flop d0.
- dff_d1  output  1  to flop d1.
- dff_sel  output  1  to flop sel.
- dff_rst  output  1  to flop rst (active-high at the flop).
- dff_q  input  1  from flop q.
- gnt  output  NREQ  one-hot grant, high from DRIVE through SAMPLE.
- ack  output  NREQ  one-cycle completion pulse to granted requester.
- clr_ack  output  1  one-cycle completion pulse for reset-check.
- rsp_q  output  1  sampled q of last completed op.
- rsp_err  output  1  mismatch flag of last completed op, valid with ack/clr_ack.
- busy  output  1  high in any state other than IDLE.
- err_cnt  output  CNT_W  saturating count of mismatches.

Behaviour:
- All outputs registered.
- Reset values: state=IDLE, dff_rst=1, dff_d0=dff_d1=dff_sel=0, gnt=0, ack=0, clr_ack=0, rsp_q=0, rsp_err=0, busy=0, err_cnt=0, rr pointer=NREQ-1 (so requester 0 wins first).
- FSM states: IDLE, DRIVE, SAMPLE.
- IDLE, clr_req=1:
  - At the edge: dff_rst<=1, expected<=0, op_is_clr<=1, go to DRIVE.
  - gnt stays 0.
- IDLE, |req=1 and clr_req=0:
  - Winner g is the first requester set, searching from pointer+1 with wrap.
  - At the edge: gnt<=onehot(g), dff_rst<=0, dff_sel<=req_path[g], expected<=req_bit[g].
  - Selected leg gets req_bit[g]; the other leg gets ~req_bit[g], so a wrong sel is detected.
  - pointer<=g; go to DRIVE.
- IDLE with no request: dff_rst<=0, hold all other flop drives.
- DRIVE (1 cycle): drives stable; flop captures at the closing edge; go to SAMPLE.
- SAMPLE (1 cycle): compare dff_q with expected. At the edge:
  - rsp_q<=dff_q, rsp_err<=(dff_q!==expected).
  - ack[g]<=1 or clr_ack<=1.
  - gnt<=0, dff_rst<=0.
  - err_cnt increments on mismatch, saturating at all-ones.
  - Go to IDLE.
- Latency: request seen in cycle T; ack high in cycle T+3.
- Throughput: IDLE arbitrates again in the cycle ack is high, so back-to-back ops run every 3 cycles.
- req dropped mid-operation: the operation still completes and the ack is still issued.
- Requests arriving during DRIVE/SAMPLE wait; no queueing beyond the level req.
- clr_req and req simultaneous: clr wins; the rr pointer is unchanged.
- dff_q containing X/Z counts as a mismatch (case-inequality compare).
- Reset mid-operation: abort immediately to reset values. No ack is issued; err_cnt is cleared.
- NREQ=1: the arbiter degenerates to a pass-through.

Decomposition:
- Package mux_dff_sched_pkg holds:
  - state_t enum {IDLE, DRIVE, SAMPLE}.
  - Path constants PATH_D0=1'b0 and PATH_D1=1'b1.
  - Function onehot().
- One sub-module, mux_dff_rr_arb:
  - Inputs: req, pointer, enable.
  - Outputs: winner index and valid.
  - Purely combinational, parameterised by NREQ.

Test Plan:
- Release reset, raise clr_req once with the flop model correct -> clr_ack at T+3, rsp_q=0, rsp_err=0, err_cnt=0.
- req[0]=1, req_bit[0]=1, req_path[0]=0 -> at T+1 dff_sel=0, dff_d0=1, dff_d1=0, gnt=4'b0001. At T+3 ack=4'b0001, rsp_q=1, rsp_err=0.
- req=4'b1111 held, bits 1,0,1,0, paths 0,1,0,1 -> acks in order 0,1,2,3,0 every 3 cycles; each rsp_q equals that requester's bit.
- Flop model with sel stuck at 0, req[2] path=1, bit=1 -> rsp_err=1, rsp_q=0, err_cnt=1. After 300 such ops with CNT_W=8, err_cnt=255.
- clr_req and req[1] raised in the same cycle -> clr serviced first (clr_ack at T+3), then req[1] (ack at T+6).
- Assert rst=0 during DRIVE -> next cycle state IDLE, gnt=0, no ack, dff_rst=1, err_cnt=0.

Source files
------------

// File: rtl/mux_dff_sched_pkg.sv
// Shared types and helpers for the mux-DFF scheduler: FSM states, mux leg
// encodings and a one-hot grant encoder.
package mux_dff_sched_pkg;

  localparam int MAX_NREQ  = 8;
  localparam int IDX_MAX_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic PATH_D0 = 1'b0;
  localparam logic PATH_D1 = 1'b1;

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
    logic [MAX_NREQ-1:0] v;
    v      = {MAX_NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_dff_sched_if.sv
// Requester-side bus of the mux-DFF scheduler: level requests in, grants,
// completion pulses and response status out.
interface mux_dff_sched_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
);

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  req_bit;
  logic [NREQ-1:0]  req_path;
  logic             clr_req;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  ack;
  logic             clr_ack;
  logic             rsp_q;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output req, req_bit, req_path, clr_req,
    input  gnt, ack, clr_ack, rsp_q, rsp_err, busy, err_cnt
  );

  modport slave (
    input  req, req_bit, req_path, clr_req,
    output gnt, ack, clr_ack, rsp_q, rsp_err, busy, err_cnt
  );

endinterface

// File: rtl/mux_dff_rr_arb.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, wrapping to the lowest set request.
module mux_dff_rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic             w_hi_found;
  logic [IDX_W-1:0] w_hi_idx;
  logic             w_lo_found;
  logic [IDX_W-1:0] w_lo_idx;

  // Lowest request above the pointer, and lowest request overall as the wrap.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = {IDX_W{1'b0}};
    w_lo_found = 1'b0;
    w_lo_idx   = {IDX_W{1'b0}};
    for (int j = 0; j < NREQ; j++) begin
      w_hi_idx   = (i_req[j] && (IDX_W'(j) > i_ptr) && !w_hi_found) ? IDX_W'(j) : w_hi_idx;
      w_hi_found = w_hi_found | (i_req[j] & (IDX_W'(j) > i_ptr));
      w_lo_idx   = (i_req[j] && !w_lo_found) ? IDX_W'(j) : w_lo_idx;
      w_lo_found = w_lo_found | i_req[j];
    end
  end

  assign o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  assign o_valid = i_en & w_lo_found;

endmodule

// File: rtl/mux_dff_sched.sv
// Round-robin scheduler sharing one 2:1-mux D flip-flop between requesters:
// drive one write, read q back a cycle later, report value and mismatch.
module mux_dff_sched
  import mux_dff_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mux_dff_sched_if.slave bus_if,
  output logic           o_dff_d0,
  output logic           o_dff_d1,
  output logic           o_dff_sel,
  output logic           o_dff_rst,
  input  logic           i_dff_q
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_ack;
  logic             r_clr_ack;
  logic             r_rsp_q;
  logic             r_rsp_err;
  logic             r_busy;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_dff_d0;
  logic             r_dff_d1;
  logic             r_dff_sel;
  logic             r_dff_rst;
  logic             r_exp;
  logic             r_is_clr;
  logic [IDX_W-1:0] r_ptr;

  state_t           w_state_nx;
  logic [NREQ-1:0]  w_gnt_nx;
  logic [NREQ-1:0]  w_ack_nx;
  logic             w_clr_ack_nx;
  logic             w_rsp_q_nx;
  logic             w_rsp_err_nx;
  logic [CNT_W-1:0] w_err_cnt_nx;
  logic             w_dff_d0_nx;
  logic             w_dff_d1_nx;
  logic             w_dff_sel_nx;
  logic             w_dff_rst_nx;
  logic             w_exp_nx;
  logic             w_is_clr_nx;
  logic [IDX_W-1:0] w_ptr_nx;

  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_valid;
  logic [NREQ-1:0]  w_win_oh;
  logic             w_mismatch;

  mux_dff_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (bus_if.req),
    .i_ptr   (r_ptr),
    .i_en    ((r_state == IDLE) && !bus_if.clr_req),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  assign w_win_oh   = NREQ'(onehot(IDX_MAX_W'(w_win_idx)));
  // Case inequality so an undriven or unknown q counts as a mismatch.
  assign w_mismatch = (i_dff_q !== r_exp);

  // Next-state and next-output decode.
  always_comb begin
    w_state_nx   = r_state;
    w_gnt_nx     = r_gnt;
    w_ack_nx     = {NREQ{1'b0}};
    w_clr_ack_nx = 1'b0;
    w_rsp_q_nx   = r_rsp_q;
    w_rsp_err_nx = r_rsp_err;
    w_err_cnt_nx = r_err_cnt;
    w_dff_d0_nx  = r_dff_d0;
    w_dff_d1_nx  = r_dff_d1;
    w_dff_sel_nx = r_dff_sel;
    w_dff_rst_nx = r_dff_rst;
    w_exp_nx     = r_exp;
    w_is_clr_nx  = r_is_clr;
    w_ptr_nx     = r_ptr;
    case (r_state)
      IDLE: begin
        if (bus_if.clr_req) begin
          w_dff_rst_nx = 1'b1;
          w_exp_nx     = 1'b0;
          w_is_clr_nx  = 1'b1;
          w_state_nx   = DRIVE;
        end else if (w_win_valid) begin
          w_gnt_nx     = w_win_oh;
          w_dff_rst_nx = 1'b0;
          w_dff_sel_nx = bus_if.req_path[w_win_idx];
          // Unselected leg carries the complement so a wrong sel shows up in q.
          if (bus_if.req_path[w_win_idx] == PATH_D1) begin
            w_dff_d1_nx = bus_if.req_bit[w_win_idx];
            w_dff_d0_nx = ~bus_if.req_bit[w_win_idx];
          end else begin
            w_dff_d0_nx = bus_if.req_bit[w_win_idx];
            w_dff_d1_nx = ~bus_if.req_bit[w_win_idx];
          end
          w_exp_nx     = bus_if.req_bit[w_win_idx];
          w_is_clr_nx  = 1'b0;
          w_ptr_nx     = w_win_idx;
          w_state_nx   = DRIVE;
        end else begin
          w_dff_rst_nx = 1'b0;
        end
      end
      DRIVE: begin
        w_state_nx = SAMPLE;
      end
      SAMPLE: begin
        w_rsp_q_nx   = i_dff_q;
        w_rsp_err_nx = w_mismatch;
        if (r_is_clr) begin
          w_clr_ack_nx = 1'b1;
        end else begin
          w_ack_nx = r_gnt;
        end
        if (w_mismatch && (r_err_cnt != {CNT_W{1'b1}})) begin
          w_err_cnt_nx = r_err_cnt + CNT_W'(1'b1);
        end else begin
          w_err_cnt_nx = r_err_cnt;
        end
        w_gnt_nx     = {NREQ{1'b0}};
        w_dff_rst_nx = 1'b0;
        w_state_nx   = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_gnt     <= {NREQ{1'b0}};
      r_ack     <= {NREQ{1'b0}};
      r_clr_ack <= 1'b0;
      r_rsp_q   <= 1'b0;
      r_rsp_err <= 1'b0;
      r_busy    <= 1'b0;
      r_err_cnt <= {CNT_W{1'b0}};
      r_dff_d0  <= 1'b0;
      r_dff_d1  <= 1'b0;
      r_dff_sel <= 1'b0;
      r_dff_rst <= 1'b1;
      r_exp     <= 1'b0;
      r_is_clr  <= 1'b0;
      r_ptr     <= IDX_W'(NREQ - 1);
    end else begin
      r_state   <= w_state_nx;
      r_gnt     <= w_gnt_nx;
      r_ack     <= w_ack_nx;
      r_clr_ack <= w_clr_ack_nx;
      r_rsp_q   <= w_rsp_q_nx;
      r_rsp_err <= w_rsp_err_nx;
      r_busy    <= (w_state_nx != IDLE);
      r_err_cnt <= w_err_cnt_nx;
      r_dff_d0  <= w_dff_d0_nx;
      r_dff_d1  <= w_dff_d1_nx;
      r_dff_sel <= w_dff_sel_nx;
      r_dff_rst <= w_dff_rst_nx;
      r_exp     <= w_exp_nx;
      r_is_clr  <= w_is_clr_nx;
      r_ptr     <= w_ptr_nx;
    end
  end

  assign bus_if.gnt     = r_gnt;
  assign bus_if.ack     = r_ack;
  assign bus_if.clr_ack = r_clr_ack;
  assign bus_if.rsp_q   = r_rsp_q;
  assign bus_if.rsp_err = r_rsp_err;
  assign bus_if.busy    = r_busy;
  assign bus_if.err_cnt = r_err_cnt;
  assign o_dff_d0       = r_dff_d0;
  assign o_dff_d1       = r_dff_d1;
  assign o_dff_sel      = r_dff_sel;
  assign o_dff_rst      = r_dff_rst;

endmodule
